// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants for the DDS waveform path
package dds_pkg;

  localparam logic [3:0] WAVE_OFF = 4'b0000;
  localparam logic [3:0] WAVE_SIN = 4'b0001;
  localparam logic [3:0] WAVE_SQU = 4'b0010;
  localparam logic [3:0] WAVE_TRI = 4'b0100;
  localparam logic [3:0] WAVE_SAW = 4'b1000;

  // 20 ms hold at 50 MHz
  localparam int DEB_CNT_MAX = 999_999;

endpackage

// File: rtl/key_filter.sv
// rtl/key_filter.sv - synchroniser, saturating debounce counter and press flag for one key
module key_filter
  import dds_pkg::*;
#(
  parameter int CNT_MAX = DEB_CNT_MAX
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_PRE = CW'(CNT_MAX - 1);

  logic key_m;
  logic key_s;
  logic [CW-1:0] cnt;

  // Counter saturates at CNT_TOP so a held key flags once and never wraps.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_m    <= 1'b1;
      key_s    <= 1'b1;
      cnt      <= '0;
      key_flag <= 1'b0;
    end else begin
      key_m    <= key_in;
      key_s    <= key_m;
      key_flag <= !key_s && (cnt == CNT_PRE);
      if (key_s) begin
        cnt <= '0;
      end else if (cnt < CNT_TOP) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_wave_sel.sv
// rtl/key_wave_sel.sv - debounced key presses to one-hot waveform select with toggle-off
module key_wave_sel
  import dds_pkg::*;
#(
  parameter int CNT_MAX = DEB_CNT_MAX,
  parameter int KEY_W   = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key_n,
  output logic [KEY_W-1:0] key_flag,
  output logic [KEY_W-1:0] wave_sel
);

  logic [KEY_W-1:0] pick;

  for (genvar g = 0; g < KEY_W; g++) begin : g_key
    key_filter #(
      .CNT_MAX(CNT_MAX)
    ) u_key_filter (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_in   (key_n[g]),
      .key_flag (key_flag[g])
    );
  end

  // Isolate the lowest set flag so simultaneous presses resolve to the lowest index.
  assign pick = key_flag & (~key_flag + KEY_W'(1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wave_sel <= KEY_W'(WAVE_OFF);
    end else if (|key_flag) begin
      wave_sel <= (wave_sel == pick) ? '0 : pick;
    end
  end

endmodule

// File: tb/tb_key_wave_sel.sv
// tb/tb_key_wave_sel.sv - directed and randomized bench for key_wave_sel against a run-length model
module tb_key_wave_sel;

  localparam int CNT = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic [3:0] key_flag;
  logic [3:0] wave_sel;

  int passes = 0;
  int total = 0;
  int tick_no = 0;
  int fcnt [4];
  int fat [4];

  // Model: length of the current low run per key, as seen one and two edges ago.
  int h1 [4];
  int h2 [4];
  logic [3:0] exp_flag = 4'h0;
  logic [3:0] exp_wave = 4'h0;

  int rem [4];

  key_wave_sel #(
    .CNT_MAX(CNT),
    .KEY_W  (4)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .key_n    (key_n),
    .key_flag (key_flag),
    .wave_sel (wave_sel)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      h1[i] = 0;
      h2[i] = 0;
    end
    exp_flag = 4'h0;
    exp_wave = 4'h0;
  endtask

  // A flag appears two edges after a low run reaches exactly CNT samples.
  task automatic model_step();
    logic [3:0] nf;
    int lo;
    if (exp_flag != 4'h0) begin
      lo = 0;
      for (int i = 3; i >= 0; i--) if (exp_flag[i]) lo = i;
      exp_wave = (exp_wave == (4'b0001 << lo)) ? 4'h0 : (4'b0001 << lo);
    end
    for (int i = 0; i < 4; i++) begin
      nf[i] = (h2[i] == CNT);
      h2[i] = h1[i];
      h1[i] = key_n[i] ? 0 : h1[i] + 1;
    end
    exp_flag = nf;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    tick_no++;
    for (int i = 0; i < 4; i++) begin
      if (key_flag[i]) begin
        fcnt[i]++;
        fat[i] = tick_no;
      end
    end
    chk("key_flag", key_flag, exp_flag);
    chk("wave_sel", wave_sel, exp_wave);
    chk("onehot0", $onehot0(wave_sel), 1);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      fcnt[i] = 0;
      fat[i] = 0;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_flag", key_flag, 0);
    chk("rst_wave", wave_sel, 0);
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_flag", key_flag, 0);
      chk("rst_hold_wave", wave_sel, 0);
    end
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [3:0] mask, input int low_cycles, input int high_cycles);
    key_n = ~mask;
    repeat (low_cycles) tick();
    key_n = 4'hF;
    repeat (high_cycles) tick();
  endtask

  initial begin
    int mark;
    model_clear();
    clear_counts();
    @(negedge clk);
    do_reset(2);

    // Idle after reset
    repeat (200) tick();
    chk("idle_wave", wave_sel, 4'b0000);

    // Clean press of key 0
    clear_counts();
    mark = tick_no;
    press(4'b0001, 100, 10);
    chk("k0_count", fcnt[0], 1);
    chk("k0_latency", fat[0] - mark - 1, 21);
    chk("k0_wave", wave_sel, 4'b0001);

    // Bouncing key 2
    clear_counts();
    press(4'b0100, 5, 3);
    press(4'b0100, 8, 3);
    press(4'b0100, 12, 3);
    mark = tick_no;
    press(4'b0100, 40, 10);
    chk("k2_bounce_count", fcnt[2], 1);
    chk("k2_latency", fat[2] - mark - 1, 21);
    chk("k2_wave", wave_sel, 4'b0100);

    // Re-press toggles off, then other keys
    press(4'b0100, 30, 5);
    chk("k2_off", wave_sel, 4'b0000);
    press(4'b1000, 30, 5);
    chk("k3_wave", wave_sel, 4'b1000);
    press(4'b0010, 30, 5);
    chk("k1_wave", wave_sel, 4'b0010);
    press(4'b0010, 30, 5);
    chk("k1_off", wave_sel, 4'b0000);

    // Simultaneous keys 1 and 3
    clear_counts();
    press(4'b1010, 30, 5);
    chk("sim_k1", fcnt[1], 1);
    chk("sim_k3", fcnt[3], 1);
    chk("sim_same_cycle", fat[1], fat[3]);
    chk("sim_wave", wave_sel, 4'b0010);

    // Reset while key 0 is held
    clear_counts();
    key_n = 4'b1110;
    repeat (15) tick();
    do_reset(2);
    mark = tick_no;
    repeat (40) tick();
    key_n = 4'hF;
    repeat (5) tick();
    chk("rstk_count", fcnt[0], 1);
    chk("rstk_latency", fat[0] - mark - 1, 21);
    chk("rstk_wave", wave_sel, 4'b0001);

    // Randomized key activity around the debounce threshold
    for (int i = 0; i < 4; i++) rem[i] = $urandom_range(1, 30);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          key_n[i] = ~key_n[i];
          rem[i] = ($urandom % 2) ? $urandom_range(17, 23) : $urandom_range(1, 45);
        end
        rem[i]--;
      end
      if (c == 1500) do_reset($urandom_range(1, 3));
      tick();
    end

    key_n = 4'hF;
    repeat (30) tick();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
